// File: rtl/matmul_job_arbiter.sv
// matmul_job_arbiter
//   Two-requester front end for a shared matrix-multiply engine. One job is
//   in flight at a time: the granted requester's operands are latched, the
//   engine gets a one-cycle clear pulse, then a start level until it reports
//   done or the RUN timer expires. The result (or a zeroed, error-flagged
//   result on abort) is presented to the owner until it takes it. After each
//   response, priority moves to the other requester.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   reqN_valid/ready/a/b      job request handshake and operands (N = 0, 1)
//   rspN_valid/ready          result handshake per requester
//   rsp_c, rsp_err            shared result matrix and abort flag
//   mult_rst/start/a/b        control and operands to the engine
//   mult_c, mult_done         engine result and completion
//   busy                      a job is in flight
//
// state | meaning
// IDLE  | waiting for a request, grant is combinational
// CLEAR | one-cycle clear pulse to the engine
// RUN   | engine running, cycle counter advancing
// RESP  | result held for the owner until it is taken
module matmul_job_arbiter #(
  parameter  int WIDTH       = 16,
  parameter  int MATRIX_SIZE = 16,
  parameter  int TIMEOUT     = 64,
  localparam int OPW         = WIDTH * MATRIX_SIZE * MATRIX_SIZE,
  localparam int RSW         = 2 * OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_a,
  input  logic [OPW-1:0] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_a,
  input  logic [OPW-1:0] req1_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [RSW-1:0] rsp_c,
  output logic           rsp_err,
  output logic           mult_rst,
  output logic           mult_start,
  output logic [OPW-1:0] mult_a,
  output logic [OPW-1:0] mult_b,
  input  logic [RSW-1:0] mult_c,
  input  logic           mult_done,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_RESP
  } state_t;

  state_t         r_state;
  logic           r_prio;
  logic           r_owner;
  logic           r_err;
  logic [15:0]    r_cnt;
  logic [OPW-1:0] r_a;
  logic [OPW-1:0] r_b;
  logic [RSW-1:0] r_c;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_rsp_take;
  logic w_timeout;

  // r_prio = 0 favours requester 0 when both are valid.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_gnt0     = req0_valid && (!req1_valid || !r_prio);
  assign w_gnt1     = req1_valid && (!req0_valid ||  r_prio);
  assign w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;
  assign w_timeout  = (r_cnt == 16'(TIMEOUT - 1));

  assign req0_ready = w_idle && w_gnt0;
  assign req1_ready = w_idle && w_gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req0_ready) begin
            r_a     <= req0_a;
            r_b     <= req0_b;
            r_owner <= 1'b0;
            r_state <= ST_CLEAR;
          end else if (req1_ready) begin
            r_a     <= req1_a;
            r_b     <= req1_b;
            r_owner <= 1'b1;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          // done wins over a timeout landing on the same cycle
          if (mult_done) begin
            r_c     <= mult_c;
            r_err   <= 1'b0;
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_c     <= '0;
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          if (w_rsp_take) begin
            r_prio  <= ~r_owner;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Clear is held during reset so the engine starts from a known state.
  assign mult_rst   = rst || (r_state == ST_CLEAR);
  assign mult_start = (r_state == ST_RUN);
  assign mult_a     = r_a;
  assign mult_b     = r_b;
  assign rsp0_valid = (r_state == ST_RESP) && !r_owner;
  assign rsp1_valid = (r_state == ST_RESP) &&  r_owner;
  assign rsp_c      = r_c;
  assign rsp_err    = r_err;
  assign busy       = !w_idle;

endmodule

// File: tb/tb_matmul_job_arbiter.sv
module tb_matmul_job_arbiter;

  localparam int W   = 16;
  localparam int N   = 16;
  localparam int TO  = 64;
  localparam int OPW = W * N * N;
  localparam int RSW = 2 * OPW;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid, req0_ready, req1_ready;
  logic [OPW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic           rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [RSW-1:0] rsp_c;
  logic           rsp_err;
  logic           mult_rst, mult_start;
  logic [OPW-1:0] mult_a, mult_b;
  logic [RSW-1:0] mult_c;
  logic           mult_done;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;

  matmul_job_arbiter #(.WIDTH(W), .MATRIX_SIZE(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_c(rsp_c), .rsp_err(rsp_err),
    .mult_rst(mult_rst), .mult_start(mult_start),
    .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c), .mult_done(mult_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioral engine: full matmul, done raised when its start-cycle count hits eng_done_at.
  int eng_done_at = -1;
  int e_cnt = 0;

  function automatic logic [RSW-1:0] matmul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic [RSW-1:0] c;
    logic [2*W-1:0] acc;
    c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < N; k++)
          acc = acc + 32'(a[(i*N+k)*W +: W]) * 32'(b[(k*N+j)*W +: W]);
        c[(i*N+j)*2*W +: 2*W] = acc;
      end
    return c;
  endfunction

  always @(posedge clk) begin
    if (mult_rst) e_cnt <= 0;
    else if (mult_start) e_cnt <= e_cnt + 1;
  end
  assign mult_done = mult_start && (e_cnt == eng_done_at);
  always_comb mult_c = matmul(mult_a, mult_b);

  // Expected results: requester 0 sends I x B0 (B0 = i+j), requester 1 sends 2I x B1 (B1 = i*N+j).
  function automatic logic [RSW-1:0] exp_result(input bit own, input bit err);
    logic [RSW-1:0] r;
    r = '0;
    if (!err)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          r[(i*N+j)*2*W +: 2*W] = own ? 32'(2*(i*N+j)) : 32'(i+j);
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_c(input string name, input logic [RSW-1:0] act, input logic [RSW-1:0] exp);
    int idx;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      idx = 0;
      for (int e = 0; e < N*N; e++)
        if (act[e*2*W +: 2*W] !== exp[e*2*W +: 2*W]) begin
          idx = e;
          break;
        end
      $display("FAIL %s: element %0d got %h want %h", name, idx,
               act[idx*2*W +: 2*W], exp[idx*2*W +: 2*W]);
    end
  endtask

  typedef struct {
    bit v0;
    bit v1;
    bit r0;
    bit r1;
  } gvec_t;

  typedef struct {
    bit do_rst;
    bit v0;
    bit v1;
    int done_at;
    int hold;
    bit own;
    bit err;
    int run_cyc;
  } vec_t;

  gvec_t          gtbl[4];
  vec_t           tbl[8];
  logic [RSW-1:0] prev_c;

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    prev_c = '0;
  endtask

  // Entered just after a rising edge with the DUT in IDLE; leaves just after the
  // edge that consumes the response.
  task automatic run_job(input vec_t v);
    logic [RSW-1:0] exp_c;
    logic [OPW-1:0] exp_a, exp_b;
    int  runc;
    bit  stable;
    exp_c = exp_result(v.own, v.err);
    exp_a = v.own ? req1_a : req0_a;
    exp_b = v.own ? req1_b : req0_b;
    eng_done_at = v.done_at;
    req0_valid = v.v0;
    req1_valid = v.v1;
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_rsp0_valid", rsp0_valid, 1'b0);
    chk1("idle_rsp1_valid", rsp1_valid, 1'b0);
    chk_c("idle_rsp_c_hold", rsp_c, prev_c);
    chk1("grant0", req0_ready, !v.own);
    chk1("grant1", req1_ready, v.own);
    @(posedge clk);
    #1;
    if (v.own) req1_valid = 1'b0; else req0_valid = 1'b0;
    @(negedge clk);
    chk1("clear_mult_rst", mult_rst, 1'b1);
    chk1("clear_mult_start", mult_start, 1'b0);
    chk1("clear_busy", busy, 1'b1);
    chk1("clear_no_ready", req0_ready | req1_ready, 1'b0);
    chk1("clear_operands", (mult_a == exp_a) && (mult_b == exp_b), 1'b1);
    @(negedge clk);
    runc = 0;
    while (mult_start === 1'b1 && runc < 200) begin
      runc++;
      @(negedge clk);
    end
    chk32("run_cycles", runc, v.run_cyc);
    chk1("resp_rsp0_valid", rsp0_valid, !v.own);
    chk1("resp_rsp1_valid", rsp1_valid, v.own);
    chk1("resp_err", rsp_err, v.err);
    chk1("resp_mult_start", mult_start, 1'b0);
    chk1("resp_busy", busy, 1'b1);
    chk1("resp_operands", (mult_a == exp_a) && (mult_b == exp_b), 1'b1);
    chk_c("resp_c", rsp_c, exp_c);
    if (v.hold > 0) begin
      stable = 1'b1;
      if (v.own) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        if ((v.own ? rsp1_valid : rsp0_valid) !== 1'b1 || rsp_c !== exp_c ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0)
          stable = 1'b0;
      end
      chk1("backpressure_stable", stable, 1'b1);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
    end
    if (v.own) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    prev_c = exp_c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        req0_a[(i*N+j)*W +: W] = (i == j) ? 16'd1 : 16'd0;
        req0_b[(i*N+j)*W +: W] = 16'(i + j);
        req1_a[(i*N+j)*W +: W] = (i == j) ? 16'd2 : 16'd0;
        req1_b[(i*N+j)*W +: W] = 16'(i*N + j);
      end

    //            v0    v1    r0    r1
    gtbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    gtbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    gtbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    gtbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};

    //          rst   v0    v1   done hold own   err  run
    tbl[0] = '{1'b0, 1'b1, 1'b0, 17,  0, 1'b0, 1'b0, 18};  // single job
    tbl[1] = '{1'b1, 1'b1, 1'b1,  5,  0, 1'b0, 1'b0,  6};  // contention after reset
    tbl[2] = '{1'b0, 1'b1, 1'b1,  3,  0, 1'b1, 1'b0,  4};
    tbl[3] = '{1'b0, 1'b1, 1'b1,  0,  0, 1'b0, 1'b0,  1};  // done in first RUN cycle
    tbl[4] = '{1'b0, 1'b1, 1'b1,  9,  0, 1'b1, 1'b0, 10};
    tbl[5] = '{1'b0, 1'b1, 1'b0, -1,  0, 1'b0, 1'b1, 64};  // timeout
    tbl[6] = '{1'b0, 1'b1, 1'b1, 63, 10, 1'b1, 1'b0, 64};  // done on last count + backpressure
    tbl[7] = '{1'b0, 1'b1, 1'b0, 17,  0, 1'b0, 1'b0, 18};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    prev_c = '0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mult_rst", mult_rst, 1'b1);
    chk1("rst_mult_start", mult_start, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk_c("rst_rsp_c", rsp_c, '0);
    chk1("rst_operands_zero", (mult_a == '0) && (mult_b == '0), 1'b1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk1("post_rst_mult_rst", mult_rst, 1'b0);
    for (int g = 0; g < 4; g++) begin
      req0_valid = gtbl[g].v0;
      req1_valid = gtbl[g].v1;
      #1;
      chk1("gtbl_ready0", req0_ready, gtbl[g].r0);
      chk1("gtbl_ready1", req1_ready, gtbl[g].r1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    @(posedge clk);
    #1;

    for (int t = 0; t < 8; t++) begin
      if (tbl[t].do_rst) apply_reset();
      run_job(tbl[t]);
    end

    // Reset in the middle of RUN abandons the job.
    eng_done_at = -1;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    @(negedge clk);
    chk1("mid_grant0", req0_ready, 1'b1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_mult_start", mult_start, 1'b0);
    chk1("mid_rst_mult_rst", mult_rst, 1'b1);
    chk1("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("mid_rst_rsp1_valid", rsp1_valid, 1'b0);
    chk1("mid_rst_operands_zero", mult_a == '0, 1'b1);
    req1_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("after_rst_ready1", req1_ready, 1'b1);
    chk1("after_rst_mult_rst", mult_rst, 1'b0);
    chk1("after_rst_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    chk1("after_rst_clear_pulse", mult_rst, 1'b1);
    chk1("after_rst_operands", (mult_a == req1_a) && (mult_b == req1_b), 1'b1);
    @(negedge clk);
    chk1("after_rst_run", mult_start, 1'b1);
    chk1("after_rst_pulse_end", mult_rst, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
